gcd_ctrl: RTL and testbench

- Moore/Mealy control FSM that sequences the 4-bit subtract-based GCD datapath.
- Drives the two operand-register 2:1 mux selects (external input vs. subtractor difference), the register load enables and the result load.
- Consumes comparator/zero flags from the datapath; exposes a start/busy/done/err handshake to the host, plus a synchronous abort.

---
 rtl/gcd_pkg.sv | 27 ++
 rtl/gcd_ctrl.sv | 170 +++++++++++++++++
 tb/tb_gcd_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the subtract-based GCD controller.
//   gcd_state_t      - controller state encoding
//   SEL_EXT/SEL_DIFF - operand mux select values (external operand / difference)
//   MAX_ITER_DEFAULT - default subtraction budget; 14 covers gcd(15,1)
package gcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_SUBX  = 3'd3,
        ST_SUBY  = 3'd4,
        ST_FIN   = 3'd5,
        ST_ERR   = 3'd6
    } gcd_state_t;

    localparam logic SEL_EXT  = 1'b0;
    localparam logic SEL_DIFF = 1'b1;

    localparam int MAX_ITER_DEFAULT = 14;

    // A zero operand never converges under repeated subtraction.
    function automatic logic any_zero(input logic x_zero, input logic y_zero);
        return x_zero | y_zero;
    endfunction

endpackage

// File: rtl/gcd_ctrl.sv
// gcd_ctrl: control FSM sequencing a 4-bit subtract-based GCD datapath.
// Ports:
//   clk, rst_n             - clock (rising edge), async active-low reset
//   start                  - run request, only honoured in IDLE
//   abort                  - synchronous abort, returns to IDLE without done
//   x_eq_y, x_lt_y,
//   x_zero, y_zero         - datapath comparator / zero flags
//   x_sel, y_sel           - operand mux selects (0 = external, 1 = difference)
//   x_ld, y_ld             - operand register load enables
//   out_ld                 - result register load (captures X)
//   busy, done, err        - host handshake
//   iter_cnt               - subtraction steps of the current/last run
// MAX_ITER must satisfy 2**CNT_W > MAX_ITER.
module gcd_ctrl
    import gcd_pkg::*;
#(
    parameter int MAX_ITER = MAX_ITER_DEFAULT,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             x_eq_y,
    input  logic             x_lt_y,
    input  logic             x_zero,
    input  logic             y_zero,
    output logic             x_sel,
    output logic             y_sel,
    output logic             x_ld,
    output logic             y_ld,
    output logic             out_ld,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_cnt
);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_ITER);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    gcd_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and iteration counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; abort overrides everything, including start in IDLE.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: state_d = ST_CHECK;
                ST_CHECK: begin
                    // Zero flags win over equality: gcd with a zero operand is an error.
                    if (any_zero(x_zero, y_zero)) begin
                        state_d = ST_ERR;
                    end else if (x_eq_y) begin
                        state_d = ST_FIN;
                    end else if (cnt_q == MAX_CNT) begin
                        state_d = ST_ERR;
                    end else if (x_lt_y) begin
                        state_d = ST_SUBY;
                    end else begin
                        state_d = ST_SUBX;
                    end
                end
                ST_SUBX: state_d = ST_CHECK;
                ST_SUBY: state_d = ST_CHECK;
                ST_FIN:  state_d = ST_IDLE;
                ST_ERR:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Iteration counter: cleared on accepted start, bumped per subtraction,
    // saturating, and frozen by abort.
    always_comb begin
        cnt_d = cnt_q;
        if (abort) begin
            cnt_d = cnt_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_d = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_SUBX, ST_SUBY: begin
                    if (cnt_q < MAX_CNT) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Output decode; out_ld is the only output that also looks at the flags.
    always_comb begin
        x_sel  = SEL_EXT;
        y_sel  = SEL_EXT;
        x_ld   = 1'b0;
        y_ld   = 1'b0;
        out_ld = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        err    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_LOAD: begin
                x_ld = 1'b1;
                y_ld = 1'b1;
                busy = 1'b1;
            end
            ST_CHECK: begin
                busy   = 1'b1;
                out_ld = x_eq_y & ~any_zero(x_zero, y_zero);
            end
            ST_SUBX: begin
                x_sel = SEL_DIFF;
                x_ld  = 1'b1;
                busy  = 1'b1;
            end
            ST_SUBY: begin
                y_sel = SEL_DIFF;
                y_ld  = 1'b1;
                busy  = 1'b1;
            end
            ST_FIN: begin
                done = 1'b1;
            end
            ST_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign iter_cnt = cnt_q;

endmodule

// File: tb/tb_gcd_ctrl.sv
// tb_gcd_ctrl: two controllers (MAX_ITER 14 and 13) share host stimulus, each
// driving its own small datapath model; results are compared against a table
// of hand-computed vectors and an arithmetic GCD reference.
module tb_gcd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] a_in = 4'd0;
    logic [3:0] b_in = 4'd0;

    logic x_sel0, y_sel0, x_ld0, y_ld0, out_ld0, busy0, done0, err0;
    logic x_sel1, y_sel1, x_ld1, y_ld1, out_ld1, busy1, done1, err1;
    logic [3:0] iter0, iter1;
    logic [3:0] x0 = 4'd0, y0 = 4'd0, r0 = 4'd0;
    logic [3:0] x1 = 4'd0, y1 = 4'd0, r1 = 4'd0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gcd_ctrl #(.MAX_ITER(14), .CNT_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .x_eq_y(x0 == y0), .x_lt_y(x0 < y0), .x_zero(x0 == 4'd0), .y_zero(y0 == 4'd0),
        .x_sel(x_sel0), .y_sel(y_sel0), .x_ld(x_ld0), .y_ld(y_ld0), .out_ld(out_ld0),
        .busy(busy0), .done(done0), .err(err0), .iter_cnt(iter0)
    );

    gcd_ctrl #(.MAX_ITER(13), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .x_eq_y(x1 == y1), .x_lt_y(x1 < y1), .x_zero(x1 == 4'd0), .y_zero(y1 == 4'd0),
        .x_sel(x_sel1), .y_sel(y_sel1), .x_ld(x_ld1), .y_ld(y_ld1), .out_ld(out_ld1),
        .busy(busy1), .done(done1), .err(err1), .iter_cnt(iter1)
    );

    // Datapath models: muxes, operand registers, subtractors, result register.
    always @(posedge clk) begin
        if (x_ld0) x0 <= x_sel0 ? (x0 - y0) : a_in;
        if (y_ld0) y0 <= y_sel0 ? (y0 - x0) : b_in;
        if (out_ld0) r0 <= x0;
        if (x_ld1) x1 <= x_sel1 ? (x1 - y1) : a_in;
        if (y_ld1) y1 <= y_sel1 ? (y1 - x1) : b_in;
        if (out_ld1) r1 <= x1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: Euclid by subtraction with a step budget.
    function automatic void ref_run(input int a, input int b, input int mx,
                                    output int err, output int iter,
                                    output int res, output int cyc);
        int x, y, k;
        err = 0; res = -1;
        if (a == 0 || b == 0) begin
            err = 1; iter = 0; cyc = 3;
            return;
        end
        x = a; y = b; k = 0;
        while (x != y) begin
            if (k == mx) begin
                err = 1;
                break;
            end
            if (x > y) x = x - y; else y = y - x;
            k++;
        end
        iter = k;
        cyc = 3 + 2 * k;
        if (err == 0) res = x;
    endfunction

    // One full run; expectations for instance 0 given, instance 1 from the model.
    task automatic run_op(input int a, input int b, input int e_err, input int e_iter,
                          input int e_res, input int e_cyc, input string tag);
        int dc0 = 0, dc1 = 0, er0 = 0, er1 = 0, it0 = 0, it1 = 0;
        int nld0 = 0, nld1 = 0, nload0 = 0, nload1 = 0, nd0 = 0, nd1 = 0, bad = 0;
        int m_err, m_iter, m_res, m_cyc;
        ref_run(a, b, 13, m_err, m_iter, m_res, m_cyc);
        a_in = 4'(a); b_in = 4'(b); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " load_cycle"}, int'({busy0, x_ld0, y_ld0, x_sel0, y_sel0}), 28);
        for (int c = 1; c <= 80 && (dc0 == 0 || dc1 == 0); c++) begin
            if (c > 1 && (x_ld0 || y_ld0)) nload0++;
            if (c > 1 && (x_ld1 || y_ld1)) nload1++;
            if (out_ld0) nld0++;
            if (out_ld1) nld1++;
            if (done0) nd0++;
            if (done1) nd1++;
            if (done0 && dc0 == 0) begin dc0 = c; er0 = int'(err0); it0 = int'(iter0); end
            if (done1 && dc1 == 0) begin dc1 = c; er1 = int'(err1); it1 = int'(iter1); end
            if ((!x_ld0 && x_sel0) || (!y_ld0 && y_sel0) || (err0 && !done0)) bad++;
            if ((!x_ld1 && x_sel1) || (!y_ld1 && y_sel1) || (err1 && !done1)) bad++;
            if ((done0 && busy0) || (done1 && busy1)) bad++;
            @(posedge clk); #1;
        end
        chk({tag, " done_cyc0"}, dc0, e_cyc);
        chk({tag, " err0"}, er0, e_err);
        chk({tag, " iter0"}, it0, e_iter);
        chk({tag, " outld0"}, nld0, (e_err != 0) ? 0 : 1);
        chk({tag, " loads0"}, nload0, e_iter);
        chk({tag, " done_pulses0"}, nd0, 1);
        if (e_res >= 0) chk({tag, " result0"}, int'(r0), e_res);
        chk({tag, " done_cyc1"}, dc1, m_cyc);
        chk({tag, " err1"}, er1, m_err);
        chk({tag, " iter1"}, it1, m_iter);
        chk({tag, " outld1"}, nld1, (m_err != 0) ? 0 : 1);
        chk({tag, " loads1"}, nload1, m_iter);
        chk({tag, " done_pulses1"}, nd1, 1);
        if (m_res >= 0) chk({tag, " result1"}, int'(r1), m_res);
        chk({tag, " sel_rules"}, bad, 0);
    endtask

    typedef struct {
        int a; int b; int err; int iter; int res; int cyc;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int e_err, e_iter, e_res, e_cyc;
        int ra, rb, bad;

        tbl[0] = '{12, 8, 0, 2, 4, 7};
        tbl[1] = '{15, 1, 0, 14, 1, 31};
        tbl[2] = '{0, 5, 1, 0, -1, 3};
        tbl[3] = '{9, 9, 0, 0, 9, 3};
        tbl[4] = '{5, 0, 1, 0, -1, 3};
        tbl[5] = '{7, 3, 0, 4, 1, 11};
        tbl[6] = '{1, 15, 0, 14, 1, 31};
        tbl[7] = '{0, 0, 1, 0, -1, 3};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs0", int'({x_sel0, y_sel0, x_ld0, y_ld0, out_ld0, busy0, done0, err0, iter0}), 0);
        chk("reset_outs1", int'({x_sel1, y_sel1, x_ld1, y_ld1, out_ld1, busy1, done1, err1, iter1}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors (runs are back-to-back: start in first IDLE cycle).
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].err, tbl[i].iter, tbl[i].res, tbl[i].cyc,
                   $sformatf("vec%0d", i));
        end

        // Randomized operands against the arithmetic reference.
        for (int i = 0; i < 20; i++) begin
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            ref_run(ra, rb, 14, e_err, e_iter, e_res, e_cyc);
            run_op(ra, rb, e_err, e_iter, e_res, e_cyc, $sformatf("rnd%0d_%0d_%0d", i, ra, rb));
        end

        // Abort in the second CHECK of 12/8 with start held high throughout.
        a_in = 4'd12; b_in = 4'd8; start = 1'b1;
        @(posedge clk); #1;
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_pre_busy", int'({busy0, busy1}), 3);
        chk("abort_start_ignored", int'({x_ld0, iter0}), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        chk("abort_idle0", int'({busy0, done0, err0}), 0);
        chk("abort_idle1", int'({busy1, done1, err1}), 0);
        chk("abort_iter_hold", int'(iter0), 1);
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done0 || done1 || busy0 || busy1) bad++;
        end
        chk("abort_no_done", bad, 0);

        // abort together with start in IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_start_idle", int'({busy0, busy1}), 0);
        chk("abort_start_iter", int'(iter0), 1);
        @(posedge clk); #1;
        chk("abort_start_stays", int'({busy0, busy1, x_ld0}), 0);

        // Async reset in the middle of SUBX.
        a_in = 4'd12; b_in = 4'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("subx_state", int'({x_ld0, x_sel0, busy0}), 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset0", int'({x_sel0, y_sel0, x_ld0, y_ld0, out_ld0, busy0, done0, err0, iter0}), 0);
        chk("midrun_reset1", int'({x_sel1, y_sel1, x_ld1, y_ld1, out_ld1, busy1, done1, err1, iter1}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(12, 8, 0, 2, 4, 7, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
